// File: rtl/frame_pkg.sv
// Shared definitions for the framed 16-bit stream: default header/trailer
// words, parser state encoding, and the CRC-16 and Gray helper functions.
package frame_pkg;

   localparam logic [31:0] HEADER_DEF  = 32'hE0E0E0E0;
   localparam logic [31:0] TRAILER_DEF = 32'h0E0E0E0E;

   // Widest word the CRC helper accepts, and widest vector bin2gray handles.
   localparam int CRC_MAX_W  = 64;
   localparam int GRAY_MAX_W = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR2 = 2'd1,
      ST_CHAN = 2'd2,
      ST_BODY = 2'd3
   } state_t;

   // CRC-16/XMODEM (poly 0x1021, init 0, no reflection) advanced by the low
   // nbits of word, most significant bit first.
   function automatic logic [15:0] crc16_step(input logic [15:0]          crc,
                                              input logic [CRC_MAX_W-1:0] word,
                                              input int                   nbits);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
         if (i < nbits) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   // Binary to reflected-binary Gray code over a zero-extended vector.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/crc16_par.sv
// Combinational next-CRC for one DW-bit word; shared with the TX framer.
module crc16_par
   import frame_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [15:0]   i_crc,
   input  logic [DW-1:0] i_data,
   output logic [15:0]   o_crc
);

   assign o_crc = crc16_step(i_crc, CRC_MAX_W'(i_data), DW);

endmodule

// File: rtl/frame_rx_parser.sv
// Receive parser: finds header, checks the one-hot channel word, collects the
// payload through a two-word delay line so the CRC and trailer are never
// committed, then reports one record or one error pulse per frame.
//
// Handshake: in_vld qualifies data_in. There is no backpressure; a word is
// consumed on every rising edge where in_vld=1, and edges with in_vld=0
// leave every piece of state untouched.
module frame_rx_parser
   import frame_pkg::*;
#(
   parameter  int               DW        = 16,
   parameter  int               NCH       = 8,
   parameter  int               MAX_WORDS = 8,
   parameter  logic [2*DW-1:0]  HEADER    = (2*DW)'(HEADER_DEF),
   parameter  logic [2*DW-1:0]  TRAILER   = (2*DW)'(TRAILER_DEF),
   parameter  bit               GRAY_EN   = 1'b1,
   localparam int               LW        = $clog2(MAX_WORDS + 1),
   localparam int               BW        = DW * MAX_WORDS
) (
   input  logic           clk_in,
   input  logic           rst_n,
   input  logic [DW-1:0]  data_in,
   input  logic           in_vld,
   output logic           frm_vld,
   output logic [NCH-1:0] frm_ch,
   output logic [LW-1:0]  frm_len,
   output logic [BW-1:0]  frm_data,
   output logic           crc_valid,
   output logic           crc_err,
   output logic           ch_err,
   output logic           len_err,
   output state_t         o_dbg_state
);

   localparam logic [DW-1:0] HDR_HI = HEADER[2*DW-1:DW];
   localparam logic [DW-1:0] HDR_LO = HEADER[DW-1:0];
   localparam logic [DW-1:0] TRL_HI = TRAILER[2*DW-1:DW];
   localparam logic [DW-1:0] TRL_LO = TRAILER[DW-1:0];

   state_t         r_state, w_state_nxt;
   logic [DW-1:0]  r_w0, r_w1;
   logic           r_v0, r_v1;
   logic [BW-1:0]  r_buf;
   logic [15:0]    r_crc, w_crc_nxt;
   logic [LW-1:0]  r_cnt;
   logic [NCH-1:0] r_ch;

   logic           w_ch_ok, w_eof, w_commit, w_over;
   logic           w_chan_load, w_shift, w_good, w_bad_crc, w_ch_err, w_len_err;
   logic [BW-1:0]  w_rec_data;

   // CRC advance uses the oldest pending word, which is the one being committed.
   crc16_par #(.DW(DW)) u_crc (
      .i_crc  (r_crc),
      .i_data (r_w1),
      .o_crc  (w_crc_nxt)
   );

   assign w_ch_ok    = ((data_in >> NCH) == '0) && $onehot(data_in[NCH-1:0]);
   assign w_eof      = (data_in == TRL_LO) && (r_w0 == TRL_HI) && r_v0 && r_v1;
   assign w_commit   = r_v1 && !w_eof;
   assign w_over     = w_commit && (r_cnt == LW'(MAX_WORDS));
   assign w_rec_data = GRAY_EN ? BW'(bin2gray(GRAY_MAX_W'(r_buf))) : r_buf;
   assign o_dbg_state = r_state;

   // State register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and per-word control/event decode.
   always_comb begin
      w_state_nxt = r_state;
      w_chan_load = 1'b0;
      w_shift     = 1'b0;
      w_good      = 1'b0;
      w_bad_crc   = 1'b0;
      w_ch_err    = 1'b0;
      w_len_err   = 1'b0;
      if (in_vld) begin
         case (r_state)
            ST_IDLE: if (data_in == HDR_HI) w_state_nxt = ST_HDR2;
            ST_HDR2: begin
               if (data_in == HDR_LO)      w_state_nxt = ST_CHAN;
               else if (data_in == HDR_HI) w_state_nxt = ST_HDR2;
               else                        w_state_nxt = ST_IDLE;
            end
            ST_CHAN: begin
               if (w_ch_ok) begin
                  w_chan_load = 1'b1;
                  w_state_nxt = ST_BODY;
               end else begin
                  w_ch_err    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BODY: begin
               if (w_eof) begin
                  w_state_nxt = ST_IDLE;
                  if (r_cnt == '0)        w_len_err = 1'b1;
                  else if (r_crc == r_w1) w_good    = 1'b1;
                  else                    w_bad_crc = 1'b1;
               end else if (w_over) begin
                  w_len_err   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_shift = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Payload delay line, buffer, running CRC and word count.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_w0  <= '0;
         r_w1  <= '0;
         r_v0  <= 1'b0;
         r_v1  <= 1'b0;
         r_buf <= '0;
         r_crc <= '0;
         r_cnt <= '0;
         r_ch  <= '0;
      end else if (w_chan_load) begin
         r_ch  <= data_in[NCH-1:0];
         r_buf <= '0;
         r_crc <= '0;
         r_cnt <= '0;
         r_v0  <= 1'b0;
         r_v1  <= 1'b0;
      end else if (w_shift) begin
         if (r_v1) begin
            r_buf <= (r_buf << DW) | BW'(r_w1);
            r_crc <= w_crc_nxt;
            r_cnt <= r_cnt + LW'(1);
         end
         r_w1 <= r_w0;
         r_v1 <= r_v0;
         r_w0 <= data_in;
         r_v0 <= 1'b1;
      end
   end

   // Registered outputs: pulses last one cycle, the record only moves on a good frame.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         frm_vld   <= 1'b0;
         crc_valid <= 1'b0;
         crc_err   <= 1'b0;
         ch_err    <= 1'b0;
         len_err   <= 1'b0;
         frm_ch    <= '0;
         frm_len   <= '0;
         frm_data  <= '0;
      end else begin
         frm_vld   <= w_good;
         crc_valid <= w_good;
         crc_err   <= w_bad_crc;
         ch_err    <= w_ch_err;
         len_err   <= w_len_err;
         if (w_good) begin
            frm_ch   <= r_ch;
            frm_len  <= r_cnt;
            frm_data <= w_rec_data;
         end
      end
   end

endmodule

// File: tb/tb_frame_rx_parser.sv
// Directed bench for frame_rx_parser with a scoreboard of expected frame events.
module tb_frame_rx_parser;
   import frame_pkg::*;

   localparam int NCH = 8;
   localparam int LW  = 4;
   localparam int BW  = 128;
   localparam int RW  = 2 + NCH + LW + BW;

   localparam logic [1:0] K_GOOD = 2'd0;
   localparam logic [1:0] K_CRC  = 2'd1;
   localparam logic [1:0] K_CH   = 2'd2;
   localparam logic [1:0] K_LEN  = 2'd3;

   localparam logic [15:0] HDR_W = 16'hE0E0;
   localparam logic [15:0] TRL_W = 16'h0E0E;

   logic           clk_in, rst_n, in_vld;
   logic [15:0]    data_in;
   logic           frm_vld, crc_valid, crc_err, ch_err, len_err;
   logic [NCH-1:0] frm_ch;
   logic [LW-1:0]  frm_len;
   logic [BW-1:0]  frm_data;
   state_t         dbg_state;

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] exp_q[$];
   logic [15:0]   pl[0:15];
   logic [RW-1:0] mon_e;
   logic [1:0]    mon_k;
   logic [15:0]   crc_tmp;

   frame_rx_parser dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .in_vld      (in_vld),
      .frm_vld     (frm_vld),
      .frm_ch      (frm_ch),
      .frm_len     (frm_len),
      .frm_data    (frm_data),
      .crc_valid   (crc_valid),
      .crc_err     (crc_err),
      .ch_err      (ch_err),
      .len_err     (len_err),
      .o_dbg_state (dbg_state)
   );

   // Clock.
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference CRC-16/XMODEM, bit-serial, over pl[0..n-1].
   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < n; i++) begin
         for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ pl[i][b];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // Reference record: right-aligned payload, Gray coded over the full vector.
   function automatic logic [BW-1:0] model_rec(input int n);
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < n; i++) b = (b << 16) | BW'(pl[i]);
      return b ^ (b >> 1);
   endfunction

   task automatic push_good(input logic [NCH-1:0] ch, input int n);
      exp_q.push_back({K_GOOD, ch, LW'(n), model_rec(n)});
   endtask

   task automatic push_err(input logic [1:0] kind);
      exp_q.push_back({kind, {(RW-2){1'b0}}});
   endtask

   task automatic drive(input logic [15:0] w);
      @(posedge clk_in);
      #1;
      data_in = w;
      in_vld  = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
         in_vld  = 1'b0;
         data_in = 16'($urandom_range(0, 16'hFFFF));
      end
   endtask

   task automatic send_frame(input logic [15:0] ch, input int n, input logic [15:0] crc,
                             input bit gaps);
      drive(HDR_W); if (gaps) idle(1);
      drive(HDR_W); if (gaps) idle(1);
      drive(ch);    if (gaps) idle(1);
      for (int i = 0; i < n; i++) begin
         drive(pl[i]);
         if (gaps) idle(1);
      end
      drive(crc);   if (gaps) idle(1);
      drive(TRL_W); if (gaps) idle(1);
      drive(TRL_W);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_frm_vld"},   frm_vld,   0);
      check({tag, "_crc_valid"}, crc_valid, 0);
      check({tag, "_crc_err"},   crc_err,   0);
      check({tag, "_ch_err"},    ch_err,    0);
      check({tag, "_len_err"},   len_err,   0);
      check({tag, "_frm_ch"},    frm_ch,    0);
      check({tag, "_frm_len"},   frm_len,   0);
      check({tag, "_frm_data"},  frm_data,  0);
      check({tag, "_state"},     dbg_state, ST_IDLE);
   endtask

   // Scoreboard: every event pulse pops one expected record and is compared.
   always @(negedge clk_in) begin
      if (rst_n && (frm_vld || crc_err || ch_err || len_err || crc_valid)) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_event observed=%b%b%b%b expected=none",
                   frm_vld, crc_err, ch_err, len_err);
         end
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_k = mon_e[RW-1 -: 2];
            check("ev_frm_vld",   frm_vld,   mon_k == K_GOOD);
            check("ev_crc_valid", crc_valid, mon_k == K_GOOD);
            check("ev_crc_err",   crc_err,   mon_k == K_CRC);
            check("ev_ch_err",    ch_err,    mon_k == K_CH);
            check("ev_len_err",   len_err,   mon_k == K_LEN);
            if (mon_k == K_GOOD) begin
               check("rec_ch",   frm_ch,   mon_e[RW-3 -: NCH]);
               check("rec_len",  frm_len,  mon_e[BW+LW-1 -: LW]);
               check("rec_data", frm_data, mon_e[BW-1:0]);
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      rst_n   = 1'b0;
      in_vld  = 1'b0;
      data_in = 16'h0000;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_zero_outputs("reset");
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;

      // Single-word frame with a known CRC.
      pl[0] = 16'h0001;
      push_good(8'h01, 1);
      send_frame(16'h0001, 1, 16'h1021, 1'b0);
      idle(3);

      // Two-word frame, checked against the literal Gray-coded record.
      pl[0] = 16'h1111;
      pl[1] = 16'hA55A;
      push_good(8'h02, 2);
      send_frame(16'h0002, 2, model_crc(2), 1'b0);
      idle(3);
      @(negedge clk_in);
      check("gray_literal", frm_data, 128'h199977F7);

      // Same frame with a corrupted CRC: error pulse, record untouched.
      push_err(K_CRC);
      send_frame(16'h0002, 2, 16'hFFFF, 1'b0);
      idle(3);
      @(negedge clk_in);
      check("hold_after_crc_err_data", frm_data, 128'h199977F7);
      check("hold_after_crc_err_len",  frm_len,  2);
      check("hold_after_crc_err_ch",   frm_ch,   8'h02);

      // Illegal channel word, then two frames back to back.
      push_err(K_CH);
      drive(HDR_W);
      drive(HDR_W);
      drive(16'hE0E0);
      pl[0] = 16'h0000;
      push_good(8'h04, 1);
      send_frame(16'h0004, 1, 16'h0000, 1'b0);
      pl[0] = 16'h0001;
      push_good(8'h08, 1);
      send_frame(16'h0008, 1, 16'h1021, 1'b0);
      idle(3);

      // Oversize payload.
      for (int i = 0; i < 16; i++) pl[i] = 16'hAAAA;
      push_err(K_LEN);
      send_frame(16'h0020, 16, model_crc(16), 1'b0);
      idle(3);
      @(negedge clk_in);
      check("hold_after_len_err_ch", frm_ch, 8'h08);

      // Empty payload.
      push_err(K_LEN);
      send_frame(16'h0001, 0, 16'h0000, 1'b0);
      idle(3);

      // Full 128-bit frame with in_vld toggling every cycle.
      do begin
         for (int i = 0; i < 8; i++) pl[i] = 16'($urandom_range(0, 16'h0DFF));
         crc_tmp = model_crc(8);
      end while (crc_tmp == TRL_W);
      push_good(8'h80, 8);
      send_frame(16'h0080, 8, crc_tmp, 1'b1);
      idle(3);

      // Reset in the middle of a frame.
      drive(HDR_W);  idle(1);
      drive(HDR_W);  idle(1);
      drive(16'h0001); idle(1);
      drive(16'h0123); idle(1);
      drive(16'h0456);
      @(posedge clk_in);
      #3;
      rst_n  = 1'b0;
      in_vld = 1'b0;
      @(negedge clk_in);
      check_zero_outputs("midreset");
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      drive(16'h0789);
      drive(TRL_W);
      drive(TRL_W);
      idle(3);
      @(negedge clk_in);
      check_zero_outputs("after_reset");

      // Recovery frame.
      pl[0] = 16'h1234;
      push_good(8'h10, 1);
      send_frame(16'h0010, 1, model_crc(1), 1'b0);
      idle(4);

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_rx_parser.md
# frame_rx_parser

- Single-clock, parametrised receive parser for the framed 16-bit input stream: header `E0E0_E0E0`, one-hot channel word, 1..MAX_WORDS payload words, CRC-16 word, trailer `0E0E_0E0E`.
- Successor to the fixed 8-channel/128-bit front end. Generalises word width, channel count and maximum payload, and adds:
  - an input qualifier;
  - channel-word, oversize and undersize error detection;
  - an optional Gray-coding stage.
- Emits one parallel, right-aligned payload record per good frame, for the downstream FIFO/serialiser.

## Interface
- DW, 16: word width; header, trailer and CRC are each matched per DW-bit word.
- NCH, 8: channel count; the channel word must be one-hot in [NCH-1:0].
- MAX_WORDS, 8: maximum number of payload words.
- HEADER, 32'hE0E0E0E0: header; high word first.
- TRAILER, 32'h0E0E0E0E: trailer; high word first.
- GRAY_EN, 1: 1 = frm_data is Gray coded; 0 = frm_data is binary.
- clk_in  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- data_in  in  DW  input word, big-endian.
- in_vld  in  1  data_in is accepted on an edge only when in_vld=1; tie high for continuous streams.
- frm_vld  out  1  one-cycle pulse: good frame delivered.
- frm_ch  out  NCH  one-hot channel of the delivered frame.
- frm_len  out  $clog2(MAX_WORDS+1)  payload word count, 1..MAX_WORDS.
- frm_data  out  DW*MAX_WORDS  payload, last word at LSBs, unused upper bits zero.
- crc_valid  out  1  one-cycle pulse: CRC matched (coincides with frm_vld).
- crc_err  out  1  one-cycle pulse: CRC mismatch.
- ch_err  out  1  one-cycle pulse: channel word not one-hot, or nonzero above bit NCH-1.
- len_err  out  1  one-cycle pulse: payload is zero words or exceeds MAX_WORDS.

## Operation
- **Reset values:** state IDLE; all pulses 0; frm_ch, frm_len and frm_data 0; CRC register 0; pending flags 0.
- **Word acceptance:** all state advances only on accepted words (in_vld=1). Idle cycles hold all state.
- **FSM:**
  - IDLE: word==HEADER hi -> HDR2.
  - HDR2:
    - word==HEADER lo -> CHAN;
    - word==HEADER hi -> stay;
    - otherwise -> IDLE.
    - Note: with the default header, HEADER hi equals HEADER lo (both E0E0), so the first E0E0 in HDR2 matches HEADER lo and moves to CHAN.
  - CHAN:
    - legal channel -> latch the channel, clear the payload buffer, CRC and count -> BODY;
    - illegal channel -> ch_err pulse -> IDLE; the word is discarded.
  - BODY: runs the 2-word pending line (w0 newest, w1), each with a valid flag.
- **End-of-frame detect (BODY):** the accepted word ==TRAILER lo, w0==TRAILER hi, and both pending flags set.
  - End of frame: w1 is the received CRC; go to IDLE.
    - committed count 0 -> len_err.
    - else crc_reg==w1 -> frm_vld + crc_valid.
    - else -> crc_err.
  - Otherwise:
    - if w1 is valid, commit it: shift into the buffer at the LSB, crc_reg <= next CRC, count++;
    - then w1<=w0, w0<=word.
  - A commit attempted while count==MAX_WORDS -> len_err, IDLE, frame discarded.
- **CRC:** CRC-16/XMODEM (poly 0x1021, init 0, no reflection, no xorout), DW bits per cycle, MSB first, over the payload words only.
- **Trailer ambiguity:** the first TRAILER pair found in BODY terminates the frame. HEADER patterns inside the body are ignored.
- **Gray coding (GRAY_EN=1):** frm_data = buf ^ (buf>>1) over the full DW*MAX_WORDS vector, with zeros above the payload.
- **Output hold:** frm_ch, frm_len and frm_data are loaded only with frm_vld and hold until the next good frame. Error frames do not disturb them.

## Timing
- All outputs are registered.
- The edge that accepts TRAILER lo also loads the record and the pulses; they are visible for exactly one cycle after that edge.
- Back-to-back frames need no gap: a HEADER hi may be accepted on the edge after TRAILER lo.
- Throughput: one word per cycle, sustained.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is lost.

## Structure
- **Shared package `frame_pkg`:** HEADER/TRAILER defaults, FSM state enum, function crc16_step(crc, word) (parallel 0x1021 update), function bin2gray.
- **Sub-module `crc16_par`:** combinational next-CRC of width DW, reused by the TX side.

## Test plan
- Default params, ch 8'h01, payload 0x0001, CRC 0x1021 -> frm_vld=crc_valid=1, frm_len=1, frm_data LSBs 0x0001.
- ch 8'h02, payload 0x1111,0xA55A, CRC from bench model, GRAY_EN=1 -> frm_len=2, frm_data=...0000_199977F7.
- Same frame with CRC 0xFFFF -> crc_err=1 for one cycle, frm_vld=0, previous record unchanged.
- Channel word 16'hE0E0 -> ch_err pulse; the following frame (payload 0x0000, CRC 0x0000) is delivered normally.
- Sixteen 0xAAAA payload words on ch 8'h20 -> len_err on the 9th commit; no frm_vld. Header+channel+CRC+trailer with no payload -> len_err.
- in_vld toggling 1/0 each cycle during a 128-bit frame, rst_n pulsed mid-frame in a second frame -> the first frame is delivered intact; the second produces no output, and all outputs read 0 after reset.
